// File: rtl/mac_pkg.sv
// mac_pkg: shared widths and arbiter state encoding for the MAC TX path
package mac_pkg;
  localparam int DATA_W = 64;
  localparam int USER_W = 80;
  localparam int KEEP_W = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} arb_state_t;
endpackage

// File: rtl/axis_fifo2.sv
// axis_fifo2: 2-entry registered FIFO, output driven straight from the head register
module axis_fifo2 #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] tail;
  logic do_push, do_pop;
  assign do_pop  = pop && count != 2'd0;
  assign do_push = push && (count != 2'd2 || do_pop);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      dout  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
      if (do_push && (count == 2'd0 || (count == 2'd1 && do_pop))) dout <= din;
      else if (do_pop && count == 2'd2) dout <= tail;
      if (do_push && (count == 2'd2 || (count == 2'd1 && !do_pop))) tail <= din;
    end
endmodule

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-level round-robin merge of two AXI-Stream sources into the MAC TX stream
module mac_tx_arbiter
  import mac_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_USER_W = USER_W,
  parameter int P_CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [P_DATA_W-1:0]   s0_axis_tdata,
  input  logic [P_USER_W-1:0]   s0_axis_tuser,
  input  logic [P_DATA_W/8-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [P_DATA_W-1:0]   s1_axis_tdata,
  input  logic [P_USER_W-1:0]   s1_axis_tuser,
  input  logic [P_DATA_W/8-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [P_DATA_W-1:0]   m_axis_tdata,
  output logic [P_USER_W-1:0]   m_axis_tuser,
  output logic [P_DATA_W/8-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [P_CNT_W-1:0]    o_frame_cnt0,
  output logic [P_CNT_W-1:0]    o_frame_cnt1
);
  localparam int W = P_DATA_W + P_USER_W + P_DATA_W / 8 + 1;
  arb_state_t state, state_nx;
  logic last_srv, sel, acc, acc_last;
  logic [1:0] count;
  logic [W-1:0] din, dout;
  assign sel = state == BUSY1;
  assign s0_axis_tready = state == BUSY0 && count != 2'd2;
  assign s1_axis_tready = state == BUSY1 && count != 2'd2;
  assign acc = (s0_axis_tvalid && s0_axis_tready) || (s1_axis_tvalid && s1_axis_tready);
  assign din = sel ? {s1_axis_tlast, s1_axis_tkeep, s1_axis_tuser, s1_axis_tdata}
                   : {s0_axis_tlast, s0_axis_tkeep, s0_axis_tuser, s0_axis_tdata};
  assign acc_last = acc && din[W-1];
  // On a tie the port not served last wins; the grant then holds until tlast.
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = (s0_axis_tvalid && s1_axis_tvalid) ? (last_srv ? BUSY0 : BUSY1) :
                 s0_axis_tvalid ? BUSY0 : s1_axis_tvalid ? BUSY1 : IDLE;
    else if (acc_last)
      state_nx = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state        <= IDLE;
      last_srv     <= 1'b1;
      o_frame_cnt0 <= '0;
      o_frame_cnt1 <= '0;
    end else begin
      state <= state_nx;
      if (acc_last) last_srv <= sel;
      if (acc_last && !sel) o_frame_cnt0 <= o_frame_cnt0 + P_CNT_W'(1);
      if (acc_last && sel) o_frame_cnt1 <= o_frame_cnt1 + P_CNT_W'(1);
    end
  axis_fifo2 #(.W(W)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (acc),
    .din     (din),
    .pop     (m_axis_tready),
    .dout    (dout),
    .count   (count)
  );
  assign m_axis_tvalid = count != 2'd0;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata} = dout;
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: randomized frame traffic checked against a frame-order reference model
module tb_mac_tx_arbiter;
  // A narrower counter keeps the wrap scenario short; wrap behaviour is width-independent.
  localparam int CW = 10;
  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [79:0] user;
    logic [63:0] data;
  } beat_t;
  typedef beat_t bq_t[$];

  logic clk = 1'b0, rst_n = 1'b0;
  logic [63:0] s0_tdata, s1_tdata, m_tdata;
  logic [79:0] s0_tuser, s1_tuser, m_tuser;
  logic [7:0]  s0_tkeep, s1_tkeep, m_tkeep;
  logic s0_tlast, s1_tlast, m_tlast, s0_tvalid, s1_tvalid, m_tvalid;
  logic s0_tready, s1_tready, m_tready;
  logic [CW-1:0] cnt0, cnt1;
  int tests = 0, fails = 0;
  int sent[2];
  bit abort, stop;
  bq_t got, exp;

  mac_tx_arbiter #(.P_CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .s0_axis_tdata(s0_tdata), .s0_axis_tuser(s0_tuser), .s0_axis_tkeep(s0_tkeep),
    .s0_axis_tlast(s0_tlast), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tuser(s1_tuser), .s1_axis_tkeep(s1_tkeep),
    .s1_axis_tlast(s1_tlast), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .o_frame_cnt0(cnt0), .o_frame_cnt1(cnt1)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && m_tvalid && m_tready) got.push_back({m_tlast, m_tkeep, m_tuser, m_tdata});

  task automatic drive(input int p, input logic v, input beat_t b);
    if (p == 0) {s0_tvalid, s0_tlast, s0_tkeep, s0_tuser, s0_tdata} = {v, b};
    else {s1_tvalid, s1_tlast, s1_tkeep, s1_tuser, s1_tdata} = {v, b};
  endtask

  task automatic send(input int p, input bq_t fr, input bit gaps);
    foreach (fr[i]) begin
      int n = 0;
      bit ok = 0;
      if (gaps && i > 0)
        repeat ($urandom_range(0, 2)) begin drive(p, 1'b0, '0); @(posedge clk); #1; end
      drive(p, 1'b1, fr[i]);
      while (!ok && !abort && n < 2000) begin
        @(negedge clk);
        ok = (p == 0 ? s0_tready : s1_tready) && !abort;
        n++;
      end
      if (!ok) begin
        if (!abort) begin
          tests++; fails++;
          $display("FAIL send_timeout port %0d beat %0d: no tready after %0d cycles", p, i, n);
        end
        break;
      end
      @(posedge clk); sent[p]++; #1;
    end
    drive(p, 1'b0, '0);
  endtask

  task automatic wait_drain(input int n);
    int k = 0;
    while (got.size() < n && k < 3000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear();
    got.delete(); exp.delete(); sent = '{0, 0}; abort = 0;
  endtask

  task automatic do_reset();
    m_tready = 1'b1; drive(0, 1'b0, '0); drive(1, 1'b0, '0);
    rst_n = 1'b0; repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear();
  endtask

  function automatic bq_t rand_frame(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.user = {16'(n), 16'($urandom), $urandom, 16'h0800};
      b.keep = (i == n - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      b.last = (i == n - 1);
      q.push_back(b);
    end
    return q;
  endfunction

  task automatic test_reset();
    string nm[9] = '{"s0_tready", "s1_tready", "m_tvalid", "m_tdata", "m_tuser", "m_tkeep", "m_tlast", "cnt0", "cnt1"};
    logic [79:0] obs[9];
    rst_n = 1'b0; m_tready = 1'b1; drive(0, 1'b0, '0); drive(1, 1'b0, '0);
    #12;
    obs = '{80'(s0_tready), 80'(s1_tready), 80'(m_tvalid), 80'(m_tdata), m_tuser,
            80'(m_tkeep), 80'(m_tlast), 80'(cnt0), 80'(cnt1)};
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (obs[i] !== '0) begin fails++; $display("FAIL reset_%s got %h want 0", nm[i], obs[i]); end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear();
  endtask

  task automatic test_single_frame();
    bq_t fa;
    clear();
    for (int i = 0; i < 10; i++) begin
      beat_t b;
      b.data = {8{8'(i)}};
      b.user = {16'd10, 48'd0, 16'h0800};
      b.keep = (i == 9) ? 8'hF0 : 8'hFF;
      b.last = (i == 9);
      fa.push_back(b);
    end
    foreach (fa[i]) exp.push_back(fa[i]);
    send(0, fa, 0);
    wait_drain(exp.size());
    tests++;
    if (got.size() != exp.size()) begin fails++; $display("FAIL single_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL single_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    tests++;
    if (cnt0 !== CW'(1) || cnt1 !== '0) begin fails++; $display("FAIL single_cnt got %0d/%0d want 1/0", cnt0, cnt1); end
  endtask

  task automatic test_tie();
    int last = 1;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      bq_t a, b;
      int w;
      a = rand_frame($urandom_range(2, 6));
      b = rand_frame($urandom_range(2, 6));
      w = last ? 0 : 1;
      if (w == 0) begin foreach (a[i]) exp.push_back(a[i]); foreach (b[i]) exp.push_back(b[i]); end
      else begin foreach (b[i]) exp.push_back(b[i]); foreach (a[i]) exp.push_back(a[i]); end
      last = w ? 0 : 1;
      fork
        send(0, a, 0);
        send(1, b, 0);
      join
    end
    wait_drain(exp.size());
    tests++;
    if (got.size() != exp.size()) begin fails++; $display("FAIL tie_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL tie_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    tests++;
    if (cnt0 !== CW'(2) || cnt1 !== CW'(2)) begin fails++; $display("FAIL tie_cnt got %0d/%0d want 2/2", cnt0, cnt1); end
  endtask

  task automatic test_mid_frame();
    bq_t fa, fb;
    int viol = 0;
    clear();
    fa = rand_frame(8);
    fb = rand_frame(5);
    foreach (fa[i]) exp.push_back(fa[i]);
    foreach (fb[i]) exp.push_back(fb[i]);
    fork
      send(0, fa, 0);
      begin
        int k = 0;
        while (sent[0] < 3 && k < 500) begin @(posedge clk); k++; end
        #1 send(1, fb, 0);
      end
      begin
        int k = 0;
        while (sent[0] < 8 && k < 500) begin @(negedge clk); if (s1_tready) viol++; k++; end
      end
    join
    wait_drain(exp.size());
    tests++;
    if (viol != 0) begin fails++; $display("FAIL mid_s1_tready got %0d cycles high during port0 frame want 0", viol); end
    tests++;
    if (got.size() != exp.size()) begin fails++; $display("FAIL mid_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL mid_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    bq_t fa;
    clear();
    fa = rand_frame(12);
    foreach (fa[i]) exp.push_back(fa[i]);
    fork
      send(0, fa, 0);
      begin
        int k = 0;
        while (sent[0] < 4 && k < 500) begin @(posedge clk); k++; end
        #1 m_tready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++;
        if (s0_tready !== 1'b0) begin fails++; $display("FAIL bp_s0_tready got %b want 0", s0_tready); end
        tests++;
        if (sent[0] - got.size() != 2) begin fails++; $display("FAIL bp_buffered got %0d want 2", sent[0] - got.size()); end
        @(posedge clk); #1 m_tready = 1'b1;
      end
    join
    wait_drain(exp.size());
    tests++;
    if (got.size() != exp.size()) begin fails++; $display("FAIL bp_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL bp_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    string nm[9] = '{"s0_tready", "s1_tready", "m_tvalid", "m_tdata", "m_tuser", "m_tkeep", "m_tlast", "cnt0", "cnt1"};
    logic [79:0] obs[9];
    bq_t fa, fb;
    clear();
    fa = rand_frame(8);
    fork
      send(0, fa, 0);
      begin
        int k = 0;
        while (sent[0] < 4 && k < 500) begin @(posedge clk); k++; end
        #3 rst_n = 1'b0;
        #1;
        obs = '{80'(s0_tready), 80'(s1_tready), 80'(m_tvalid), 80'(m_tdata), m_tuser,
                80'(m_tkeep), 80'(m_tlast), 80'(cnt0), 80'(cnt1)};
        for (int i = 0; i < 9; i++) begin
          tests++;
          if (obs[i] !== '0) begin fails++; $display("FAIL rstmid_%s got %h want 0", nm[i], obs[i]); end
        end
        abort = 1;
      end
    join
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear();
    fb = rand_frame(5);
    foreach (fb[i]) exp.push_back(fb[i]);
    send(0, fb, 0);
    wait_drain(exp.size());
    tests++;
    if (got.size() != exp.size()) begin fails++; $display("FAIL rstmid_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL rstmid_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    tests++;
    if (cnt0 !== CW'(1) || cnt1 !== '0) begin fails++; $display("FAIL rstmid_cnt got %0d/%0d want 1/0", cnt0, cnt1); end
  endtask

  task automatic test_wrap();
    int n = 1 << CW;
    do_reset();
    for (int k = 0; k < n; k++) begin
      send(1, rand_frame(1), 0);
      if (k == n - 2) begin
        tests++;
        if (cnt1 !== CW'(n - 1)) begin fails++; $display("FAIL wrap_max got %0d want %0d", cnt1, n - 1); end
      end
    end
    wait_drain(n);
    tests++;
    if (cnt1 !== '0 || cnt0 !== '0) begin fails++; $display("FAIL wrap_cnt got %0d/%0d want 0/0", cnt0, cnt1); end
    tests++;
    if (got.size() != n) begin fails++; $display("FAIL wrap_beats got %0d want %0d", got.size(), n); end
  endtask

  task automatic test_random();
    bq_t f0[5], f1[3];
    int i0 = 0, i1 = 0, last = 1;
    do_reset();
    foreach (f0[k]) f0[k] = rand_frame($urandom_range(1, 6));
    foreach (f1[k]) f1[k] = rand_frame($urandom_range(1, 6));
    // Both sources keep a frame pending, so grants alternate until one runs dry.
    while (i0 < 5 || i1 < 3) begin
      int w;
      w = (i0 < 5 && i1 < 3) ? (last ? 0 : 1) : (i0 < 5 ? 0 : 1);
      if (w == 0) begin for (int j = 0; j < f0[i0].size(); j++) exp.push_back(f0[i0][j]); i0++; end
      else begin for (int j = 0; j < f1[i1].size(); j++) exp.push_back(f1[i1][j]); i1++; end
      last = w;
    end
    stop = 0;
    fork
      begin
        fork
          for (int k = 0; k < 5; k++) send(0, f0[k], 1);
          for (int k = 0; k < 3; k++) send(1, f1[k], 1);
        join
        stop = 1;
      end
      begin
        while (!stop) begin m_tready = $urandom_range(0, 3) != 0; @(posedge clk); #1; end
        m_tready = 1'b1;
      end
    join
    wait_drain(exp.size());
    tests++;
    if (got.size() != exp.size()) begin fails++; $display("FAIL rand_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL rand_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    tests++;
    if (cnt0 !== CW'(5) || cnt1 !== CW'(3)) begin fails++; $display("FAIL rand_cnt got %0d/%0d want 5/3", cnt0, cnt1); end
  endtask

  initial begin
    abort = 0; m_tready = 1'b1; drive(0, 1'b0, '0); drive(1, 1'b0, '0);
    test_reset();
    test_single_frame();
    test_tie();
    test_mid_frame();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
